// File: rtl/scr_permutation_table.sv
// Builds a random permutation of 0..N-1 (identity fill, then LFSR-driven Fisher-Yates) and serves it as a table.
// Lookup latency 1 cycle, no backpressure; indices outside a finished table pass through unchanged.
module scr_permutation_table #(
    parameter int          BITS_PER_ELEMENT = 7,
    parameter logic [15:0] SEED             = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic [BITS_PER_ELEMENT:0]   num_elements_i,
    input  logic                        seed_valid_i,
    input  logic [15:0]                 seed_i,
    input  logic [BITS_PER_ELEMENT-1:0] index_i,
    output logic [31:0]                 per_o,
    output logic                        busy_o,
    output logic                        ready_o,
    output logic                        done_o
);
    localparam int             BPE     = BITS_PER_ELEMENT;
    localparam int             DEPTH   = 1 << BPE;
    localparam logic [BPE:0]   L_DEPTH = (BPE+1)'(DEPTH);
    localparam logic [BPE:0]   L_ONE   = (BPE+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_SHUFFLE, S_READY} state_t;

    state_t             r_state, w_state_nxt;
    logic [BPE:0]       r_n, r_cnt, w_n_clamp, w_ip1;
    logic [15:0]        r_lfsr, w_lfsr_step, w_seed_load;
    logic [15+BPE:0]    w_prod;
    logic [BPE-1:0]     w_j;
    logic               w_last_fill, w_unused_prod_lo, r_done;
    logic [BPE-1:0]     r_table [DEPTH];

    assign w_n_clamp   = (num_elements_i > L_DEPTH) ? L_DEPTH : num_elements_i;
    assign w_last_fill = (r_cnt + L_ONE) == r_n;
    assign w_ip1       = r_cnt + L_ONE;
    assign w_lfsr_step = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_seed_load = (seed_i == 16'h0000) ? SEED : seed_i;

    // (lfsr*(i+1)) < 2^(16+BPE), so the high BPE bits are j and j <= i
    assign w_prod           = {{BPE{1'b0}}, r_lfsr} * {15'b0, w_ip1};
    assign w_j              = w_prod[15+BPE:16];
    assign w_unused_prod_lo = ^w_prod[15:0];

    assign busy_o  = (r_state == S_FILL) || (r_state == S_SHUFFLE);
    assign ready_o = (r_state == S_READY);
    assign done_o  = r_done;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL:    if (w_last_fill) w_state_nxt = (r_n == L_ONE) ? S_READY : S_SHUFFLE;
            S_SHUFFLE: if (r_cnt == L_ONE) w_state_nxt = S_READY;
            default:   w_state_nxt = r_state;
        endcase
        if (start_i) w_state_nxt = (w_n_clamp == '0) ? S_READY : S_FILL;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_lfsr  <= SEED;
            r_n     <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            per_o   <= '0;
        end else begin
            r_state <= w_state_nxt;
            // a restart with N=0 from READY re-enters READY and still pulses
            r_done  <= (w_state_nxt == S_READY) && ((r_state != S_READY) || start_i);

            if (seed_valid_i && ((r_state == S_IDLE) || (r_state == S_READY)))
                r_lfsr <= w_seed_load;
            else if (r_state == S_SHUFFLE)
                r_lfsr <= w_lfsr_step;

            if (start_i) begin
                r_n   <= w_n_clamp;
                r_cnt <= '0;
            end else if (r_state == S_FILL && !w_last_fill) begin
                r_cnt <= r_cnt + L_ONE;
            end else if (r_state == S_SHUFFLE) begin
                r_cnt <= r_cnt - L_ONE;
            end

            if (ready_o && ({1'b0, index_i} < r_n))
                per_o <= 32'(r_table[index_i]);
            else
                per_o <= 32'(index_i);
        end
    end

    // Table contents are don't-care after reset; only FILL/SHUFFLE write it.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (r_state == S_FILL) begin
                r_table[r_cnt[BPE-1:0]] <= r_cnt[BPE-1:0];
            end else if (r_state == S_SHUFFLE) begin
                r_table[r_cnt[BPE-1:0]] <= r_table[w_j];
                r_table[w_j]            <= r_table[r_cnt[BPE-1:0]];
            end
        end
    end
endmodule

// File: tb/tb_scr_permutation_table.sv
// Directed bench for scr_permutation_table: lookups feed an expected-value queue drained by a monitor.
module tb_scr_permutation_table;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  num_elements_i = '0;
    logic        seed_valid_i = 1'b0;
    logic [15:0] seed_i = '0;
    logic [6:0]  index_i = '0;
    logic [31:0] per_o;
    logic        busy_o, ready_o, done_o;

    int n_chk = 0;
    int n_fail = 0;

    logic        look_vld = 1'b0;
    logic        look_vld_d = 1'b0;
    int          exp_q[$];

    logic [15:0] m_lfsr;
    int          m_tab [128];

    scr_permutation_table #(.BITS_PER_ELEMENT(7), .SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .num_elements_i(num_elements_i),
        .seed_valid_i(seed_valid_i), .seed_i(seed_i), .index_i(index_i),
        .per_o(per_o), .busy_o(busy_o), .ready_o(ready_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) look_vld_d <= look_vld;

    always @(negedge clk) begin
        if (look_vld_d) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL lookup: per_o=%0d with no expected value queued", per_o);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (per_o !== 32'(e)) begin
                    n_fail++;
                    $display("FAIL lookup: per_o=%0d expected %0d", per_o, e);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_step();
        m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    endtask

    task automatic model_build(input int n_in);
        int n, j, t;
        n = (n_in > 128) ? 128 : n_in;
        for (int k = 0; k < n; k++) m_tab[k] = k;
        for (int i = n - 1; i >= 1; i--) begin
            j = int'((int'(m_lfsr) * (i + 1)) >>> 16);
            t = m_tab[i]; m_tab[i] = m_tab[j]; m_tab[j] = t;
            model_step();
        end
    endtask

    task automatic start_build(input int n, input bit sv, input logic [15:0] s);
        start_i        = 1'b1;
        num_elements_i = 8'(n);
        seed_valid_i   = sv;
        seed_i         = s;
        if (sv) m_lfsr = (s == 16'h0) ? 16'hACE1 : s;
        tick();
        start_i      = 1'b0;
        seed_valid_i = 1'b0;
    endtask

    // Called in cycle 'pre'+1 after the start edge; counts busy cycles until done_o.
    task automatic wait_done(input string nm, input int exp_busy, input int exp_done, input int pre);
        int cyc, nb;
        cyc = 0; nb = 0;
        while (!done_o && cyc < 1000) begin
            if (busy_o) nb++;
            tick();
            cyc++;
        end
        chk({nm, "_busy_cycles"}, nb, exp_busy);
        chk({nm, "_done_cycle"}, pre + cyc + 1, exp_done);
        chk({nm, "_ready_at_done"}, int'(ready_o), 1);
        tick();
        chk({nm, "_done_pulse"}, int'(done_o), 0);
    endtask

    task automatic lookup(input int idx, input int exp);
        index_i  = 7'(idx);
        look_vld = 1'b1;
        exp_q.push_back(exp);
        tick();
        look_vld = 1'b0;
    endtask

    task automatic sweep(input int n);
        for (int k = 0; k < n; k++) lookup(k, m_tab[k]);
        tick();
    endtask

    initial begin
        int seen [8];
        int distinct;

        // reset with start held and a non-zero index
        m_lfsr  = 16'hACE1;
        rst     = 1'b0;
        start_i = 1'b1;
        num_elements_i = 8'd8;
        index_i = 7'd5;
        repeat (3) tick();
        chk("reset_per", int'(per_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_ready", int'(ready_o), 0);
        chk("reset_done", int'(done_o), 0);
        start_i = 1'b0;
        rst     = 1'b1;
        tick();

        // seed 0x1234, N=8
        start_build(8, 1'b1, 16'h1234);
        model_build(8);
        wait_done("n8", 15, 16, 0);
        sweep(8);

        // N=1 then N=0
        start_build(1, 1'b0, 16'h0);
        model_build(1);
        wait_done("n1", 1, 2, 0);
        lookup(0, 0);
        lookup(5, 5);
        start_build(0, 1'b0, 16'h0);
        wait_done("n0", 0, 1, 0);
        lookup(5, 5);
        tick();

        // N=200 clamps to 128, zero seed selects the default seed
        start_build(200, 1'b1, 16'h0000);
        model_build(200);
        wait_done("n200", 255, 256, 0);
        sweep(128);

        // restart N=4 during the third SHUFFLE cycle of an N=8 build
        start_build(8, 1'b1, 16'h5A5A);
        repeat (10) tick();
        chk("restart_in_shuffle", int'(busy_o), 1);
        start_build(4, 1'b0, 16'h0);
        lookup(6, 6);
        lookup(2, 2);
        wait_done("restart", 5, 8, 2);
        for (int k = 0; k < 8; k++) seen[k] = 0;
        for (int k = 0; k < 8; k++) begin
            index_i = 7'(k);
            tick();
            if (k >= 4) chk("restart_identity", int'(per_o), k);
            else if (per_o < 8) seen[per_o]++;
        end
        distinct = 0;
        for (int k = 0; k < 4; k++) if (seen[k] == 1) distinct++;
        chk("restart_perm_0_3", distinct, 4);

        // reset mid-SHUFFLE returns to IDLE with the default seed
        start_build(8, 1'b0, 16'h0);
        repeat (10) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_ready", int'(ready_o), 0);
        chk("midrst_per", int'(per_o), 0);
        m_lfsr = 16'hACE1;
        start_build(8, 1'b0, 16'h0);
        model_build(8);
        wait_done("post_rst", 15, 16, 0);
        sweep(8);
        start_build(8, 1'b1, 16'h1234);
        model_build(8);
        wait_done("repeat_n8", 15, 16, 0);
        sweep(8);

        tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
